// File: rtl/ibus_dbus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | common : bus types, size codes and arbiter enums shared by the ibus/dbus  |
// | arbiter and its winner-select sub-module.                                 |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
package common;

  typedef logic [2:0] msize_t;

  localparam msize_t MSIZE1 = 3'd0;
  localparam msize_t MSIZE2 = 3'd1;
  localparam msize_t MSIZE4 = 3'd2;
  localparam msize_t MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } mbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_IBUS = 1'b0,
    OWNER_DBUS = 1'b1
  } owner_t;

  // Fetches are always a 4-byte read; strobe/data stay zero.
  function automatic mbus_req_t ibus_to_mbus(input ibus_req_t req);
    mbus_req_t m;
    m        = '0;
    m.valid  = 1'b1;
    m.addr   = req.addr;
    m.size   = MSIZE4;
    m.strobe = 8'h00;
    m.data   = 64'h0;
    return m;
  endfunction

  function automatic mbus_req_t dbus_to_mbus(input dbus_req_t req);
    mbus_req_t m;
    m.valid  = 1'b1;
    m.addr   = req.addr;
    m.size   = req.size;
    m.strobe = req.strobe;
    m.data   = req.data;
    return m;
  endfunction

  // Pick the 32-bit instruction word out of the 64-bit memory beat.
  function automatic logic [31:0] ibus_word(input logic [63:0] beat, input logic upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage : common
`default_nettype wire

// File: rtl/ibus_dbus_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pick : combinational winner select between the fetch and data ports. |
// | A tie goes to the port that did not win last; tie i_last_grant to       |
// | OWNER_IBUS for fixed dbus priority.                                      |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module arb_pick
  import common::*;
(
  input  logic   i_ivalid,
  input  logic   i_dvalid,
  input  owner_t i_last_grant,
  output logic   o_any,
  output owner_t o_grant
);

  always_comb begin
    o_any   = i_ivalid | i_dvalid;
    o_grant = OWNER_DBUS;
    if (i_ivalid && i_dvalid) begin
      o_grant = (i_last_grant == OWNER_DBUS) ? OWNER_IBUS : OWNER_DBUS;
    end else if (i_ivalid) begin
      o_grant = OWNER_IBUS;
    end
  end

endmodule : arb_pick
`default_nettype wire

// File: rtl/ibus_dbus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibus_dbus_arbiter : shares one memory bus between instruction fetch and  |
// | data ports, one outstanding transaction. Define ARB_ROUND_ROBIN_EN for  |
// | round-robin ties; default is fixed dbus priority.                       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module ibus_dbus_arbiter
  import common::*;
(
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mbus_req_t  mreq,
  input  mbus_resp_t mresp
);

  arb_state_t  r_state;
  owner_t      r_owner;
  mbus_req_t   r_mreq;
  logic [63:0] r_data;

  owner_t      w_last_hint;
  owner_t      w_win;
  logic        w_any;
  logic        w_resp;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t      r_last_grant;
  assign w_last_hint = r_last_grant;
`else
  assign w_last_hint = OWNER_IBUS;
`endif

  arb_pick u_pick (
    .i_ivalid     (ireq.valid),
    .i_dvalid     (dreq.valid),
    .i_last_grant (w_last_hint),
    .o_any        (w_any),
    .o_grant      (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWNER_DBUS;
      r_mreq  <= '0;
      r_data  <= 64'h0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_grant <= OWNER_IBUS;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= ISSUE;
            r_owner <= w_win;
            r_mreq  <= (w_win == OWNER_DBUS) ? dbus_to_mbus(dreq) : ibus_to_mbus(ireq);
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= w_win;
`endif
          end
        end
        ISSUE: begin
          // A data_ok without addr_ok is a protocol violation and is dropped here.
          if (mresp.addr_ok) begin
            r_mreq.valid <= 1'b0;
            if (mresp.data_ok) begin
              r_data  <= mresp.data;
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mresp.data_ok) begin
            r_data  <= mresp.data;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_resp = (r_state == RESP);
  assign mreq   = r_mreq;

  // Response pulse is a decode of registered state only, so it cannot glitch.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (w_resp) begin
      if (r_owner == OWNER_IBUS) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = ibus_word(r_data, r_mreq.addr[2]);
      end else begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = r_data;
      end
    end
  end

endmodule : ibus_dbus_arbiter
`default_nettype wire

// File: tb/tb_ibus_dbus_arbiter.sv
`default_nettype none
// Directed and randomized bench for ibus_dbus_arbiter against a timeline model.
module tb_ibus_dbus_arbiter;
  import common::*;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mbus_req_t  mreq;
  mbus_resp_t mresp;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ibus_dbus_arbiter dut (
    .clk   (clk),
    .rst   (rst),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ireq  = '0;
    dreq  = '0;
    mresp = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input mbus_req_t exp);
    vectors++;
    assert (mreq === exp) else begin
      miscompares++;
      $error("FAIL %s: observed mreq %h expected %h", tag, mreq, exp);
    end
  endtask

  task automatic chk_i(input string tag, input ibus_resp_t exp);
    vectors++;
    assert (iresp === exp) else begin
      miscompares++;
      $error("FAIL %s: observed iresp %h expected %h", tag, iresp, exp);
    end
  endtask

  task automatic chk_d(input string tag, input dbus_resp_t exp);
    vectors++;
    assert (dresp === exp) else begin
      miscompares++;
      $error("FAIL %s: observed dresp %h expected %h", tag, dresp, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int w;
    w = 0;
    while (mreq.valid !== 1'b1 && w < 8) begin
      tick();
      w++;
    end
    chk(tag, 64'(mreq.valid), 64'd1);
  endtask

  function automatic mbus_req_t exp_i(input logic [63:0] a);
    mbus_req_t m;
    m.valid = 1'b1; m.addr = a; m.size = 3'd2; m.strobe = 8'h00; m.data = 64'h0;
    return m;
  endfunction

  function automatic mbus_req_t exp_d(input dbus_req_t d);
    mbus_req_t m;
    m.valid = 1'b1; m.addr = d.addr; m.size = d.size; m.strobe = d.strobe; m.data = d.data;
    return m;
  endfunction

  function automatic ibus_resp_t ipulse(input logic [63:0] beat, input logic upper);
    ibus_resp_t r;
    r.addr_ok = 1'b1;
    r.data_ok = 1'b1;
    r.data    = upper ? beat[63:32] : beat[31:0];
    return r;
  endfunction

  function automatic dbus_resp_t dpulse(input logic [63:0] beat);
    dbus_resp_t r;
    r.addr_ok = 1'b1;
    r.data_ok = 1'b1;
    r.data    = beat;
    return r;
  endfunction

  initial begin
    logic [63:0] md;
    mbus_req_t   em;
    bit          act, own_d, win_d, rr_last_d, pi_prev, pd_prev, saw_i, saw_d;
    int          c, t_addr, t_data, free_from;

    // Reset values
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    chk_m("reset mreq", '0);
    chk_i("reset iresp", '0);
    chk_d("reset dresp", '0);

    // Single ibus fetch: addr_ok cycle 1, data_ok cycle 3, pulse cycle 4
    rst = 1'b0;
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0004;
    tick();
    chk_m("fetch mreq", exp_i(64'h8000_0004));
    mresp.addr_ok = 1'b1;
    tick();
    mresp = '0;
    chk("fetch wait mreq.valid", 64'(mreq.valid), 64'd0);
    tick();
    chk_i("fetch iresp early", '0);
    mresp.data_ok = 1'b1; mresp.data = 64'h1111_2222_3333_4444;
    tick();
    mresp = '0;
    chk_i("fetch iresp", ipulse(64'h1111_2222_3333_4444, 1'b1));
    chk_d("fetch dresp", '0);
    tick();
    ireq = '0;
    chk_i("fetch iresp clear", '0);
    tick();
    chk("fetch stale guard 1", 64'(mreq.valid), 64'd0);
    tick();
    chk("fetch stale guard 2", 64'(mreq.valid), 64'd0);

    // dbus write with simultaneous addr_ok/data_ok
    dreq = '{valid: 1'b1, addr: 64'h100, size: 3'd3, strobe: 8'hFF, data: 64'hDEAD_BEEF_0000_0001};
    tick();
    chk_m("dwrite mreq", exp_d(dreq));
    chk_i("dwrite iresp c1", '0);
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0123_4567_89AB_CDEF};
    tick();
    mresp = '0;
    chk_d("dwrite dresp", dpulse(64'h0123_4567_89AB_CDEF));
    chk_i("dwrite iresp c2", '0);
    dreq = '0;
    ireq.valid = 1'b1; ireq.addr = 64'h40;
    tick();
    chk_d("dwrite dresp clear", '0);
    chk_i("dwrite iresp c3", '0);
    chk("dwrite resp is one cycle", 64'(mreq.valid), 64'd0);
    tick();
    chk_m("fetch after write", exp_i(64'h40));
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hAAAA_BBBB_CCCC_DDDD};
    tick();
    mresp = '0;
    chk_i("fetch low word", ipulse(64'hAAAA_BBBB_CCCC_DDDD, 1'b0));
    ireq = '0;
    tick();

    // Both ports held continuously for four transactions
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ireq.valid = 1'b1; ireq.addr = 64'h1000;
    dreq = '{valid: 1'b1, addr: 64'h2000, size: 3'd3, strobe: 8'h00, data: 64'h0};
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("tie grant %0d", k));
`ifdef ARB_ROUND_ROBIN_EN
      win_d = (k % 2 == 0);
`else
      win_d = 1'b1;
`endif
      chk($sformatf("tie owner %0d", k), mreq.addr, win_d ? 64'h2000 : 64'h1000);
      md = {$urandom, $urandom};
      mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: md};
      tick();
      mresp = '0;
      if (win_d) begin
        chk_d($sformatf("tie dresp %0d", k), dpulse(md));
        chk_i($sformatf("tie iresp quiet %0d", k), '0);
      end else begin
        chk_i($sformatf("tie iresp %0d", k), ipulse(md, 1'b0));
        chk_d($sformatf("tie dresp quiet %0d", k), '0);
      end
    end
    idle_inputs();
    repeat (2) tick();

    // Reset while in WAIT, then stale data_ok after release
    ireq.valid = 1'b1; ireq.addr = 64'h2004;
    tick();
    chk_m("rstwait mreq", exp_i(64'h2004));
    mresp.addr_ok = 1'b1;
    tick();
    mresp = '0;
    rst = 1'b1;
    #1;
    chk_m("rstwait mreq zero", '0);
    chk_i("rstwait iresp zero", '0);
    chk_d("rstwait dresp zero", '0);
    tick();
    rst = 1'b0;
    ireq.addr = 64'h3000;
    mresp.data_ok = 1'b1; mresp.data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk_m("post-reset grant", exp_i(64'h3000));
    chk_i("post-reset stale data_ok", '0);
    tick();
    chk_m("data_ok without addr_ok", exp_i(64'h3000));
    chk_i("data_ok without addr_ok iresp", '0);
    md = 64'h5555_6666_7777_8888;
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: md};
    tick();
    mresp = '0;
    chk_i("post-reset iresp", ipulse(md, 1'b0));
    ireq = '0;
    repeat (2) tick();

    // addr_ok held low for 10 cycles while dreq wanders
    dreq = '{valid: 1'b1, addr: 64'h0000_0000_0000_0A08, size: 3'd1, strobe: 8'h0C, data: 64'h1234_5678_9ABC_DEF0};
    tick();
    em = exp_d(dreq);
    chk_m("stall mreq start", em);
    for (int k = 0; k < 10; k++) begin
      dreq.addr   = {$urandom, $urandom};
      dreq.data   = {$urandom, $urandom};
      dreq.strobe = 8'($urandom);
      tick();
      chk_m($sformatf("stall mreq %0d", k), em);
    end
    md = {$urandom, $urandom};
    mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: md};
    tick();
    mresp = '0;
    chk_d("stall dresp", dpulse(md));
    idle_inputs();
    repeat (2) tick();

    // Randomized traffic against a transaction timeline model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c = 0; act = 1'b0; own_d = 1'b0; rr_last_d = 1'b0; free_from = 1;
    t_addr = 0; t_data = 0; em = '0; md = '0;
    saw_i = 1'b0; saw_d = 1'b0;
    for (int n = 0; n < 600; n++) begin
      mresp.addr_ok = 1'b0;
      mresp.data_ok = 1'b0;
      mresp.data    = {$urandom, $urandom};
      if (act && c == t_addr) mresp.addr_ok = 1'b1;
      if (act && c == t_data) begin
        mresp.data_ok = 1'b1;
        md = mresp.data;
      end else if (!(act && c >= t_addr && c <= t_data) && $urandom_range(0, 7) == 0) begin
        mresp.data_ok = 1'b1;
      end
      if (saw_i || !ireq.valid) begin
        ireq.valid = ($urandom_range(0, 1) == 1);
        ireq.addr  = {$urandom, $urandom};
      end
      if (saw_d || !dreq.valid) begin
        dreq.valid  = ($urandom_range(0, 1) == 1);
        dreq.addr   = {$urandom, $urandom};
        dreq.size   = 3'($urandom_range(0, 3));
        dreq.strobe = 8'($urandom);
        dreq.data   = {$urandom, $urandom};
      end
      pi_prev = ireq.valid;
      pd_prev = dreq.valid;

      tick();
      c++;
      saw_i = 1'b0;
      saw_d = 1'b0;
      if (act && c == t_data + 1) begin
        if (own_d) begin
          chk_d("rnd dresp", dpulse(md));
          chk_i("rnd iresp quiet", '0);
          saw_d = 1'b1;
        end else begin
          chk_i("rnd iresp", ipulse(md, em.addr[2]));
          chk_d("rnd dresp quiet", '0);
          saw_i = 1'b1;
        end
        act = 1'b0;
      end else begin
        chk_i("rnd iresp idle", '0);
        chk_d("rnd dresp idle", '0);
      end
      if (!act && c >= free_from && (pi_prev || pd_prev)) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = (pi_prev && pd_prev) ? !rr_last_d : pd_prev;
`else
        win_d = pd_prev;
`endif
        rr_last_d = win_d;
        own_d     = win_d;
        em        = win_d ? exp_d(dreq) : exp_i(ireq.addr);
        act       = 1'b1;
        t_addr    = c + int'($urandom_range(0, 3));
        t_data    = t_addr + int'($urandom_range(0, 3));
        free_from = t_data + 3;
      end
      if (act && c <= t_addr) begin
        chk_m("rnd mreq", em);
      end else begin
        chk("rnd mreq idle", 64'(mreq.valid), 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ibus_dbus_arbiter
`default_nettype wire
